// File: rtl/alu_operand_latch.sv
// Operand collector between the shared data bus and the ALU: gathers A, B and
// the opcode in any order, then holds the complete set under a valid/ready handshake.
module alu_operand_latch #(
    parameter int                    WIDTH      = 16,
    parameter int                    OPW        = 4,
    parameter logic [(2**OPW)-1:0]   UNARY_MASK = 'h0300
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] bus_in,
    input  logic [OPW-1:0]   opcode_in,
    input  logic             load_a,
    input  logic             load_b,
    input  logic             load_op,
    input  logic             clear,
    input  logic             alu_ready,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [OPW-1:0]   op_out,
    output logic             operands_valid,
    output logic             busy,
    output logic             proto_err
);

    typedef enum logic {
        COLLECT = 1'b0,
        ISSUE   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [OPW-1:0]   op_q, op_d;
    logic             have_a_q, have_a_d;
    logic             have_b_q, have_b_d;
    logic             have_op_q, have_op_d;
    logic             proto_err_q, proto_err_d;
    logic             any_load;

    assign any_load = load_a | load_b | load_op;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        have_a_d    = have_a_q;
        have_b_d    = have_b_q;
        have_op_d   = have_op_q;
        proto_err_d = proto_err_q;

        if (clear) begin
            state_d     = COLLECT;
            have_a_d    = 1'b0;
            have_b_d    = 1'b0;
            have_op_d   = 1'b0;
            proto_err_d = 1'b0;
        end else if (state_q == COLLECT) begin
            if (load_a) begin
                a_d      = bus_in;
                have_a_d = 1'b1;
            end
            if (load_b) begin
                b_d      = bus_in;
                have_b_d = 1'b1;
            end
            if (load_op) begin
                op_d      = opcode_in;
                have_op_d = 1'b1;
            end
            // Completion looks at this cycle's loads so valid follows the last load by one cycle.
            if (have_a_d && have_op_d && (have_b_d || UNARY_MASK[op_d])) begin
                state_d = ISSUE;
            end
        end else begin
            // Loads during ISSUE are dropped, even in the acceptance cycle.
            if (any_load) begin
                proto_err_d = 1'b1;
            end
            if (alu_ready) begin
                state_d   = COLLECT;
                have_a_d  = 1'b0;
                have_b_d  = 1'b0;
                have_op_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= COLLECT;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            have_a_q    <= 1'b0;
            have_b_q    <= 1'b0;
            have_op_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            have_a_q    <= have_a_d;
            have_b_q    <= have_b_d;
            have_op_q   <= have_op_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Unary opcodes present a zero B so a stale operand never reaches the ALU.
    assign a_out          = a_q;
    assign b_out          = UNARY_MASK[op_q] ? '0 : b_q;
    assign op_out         = op_q;
    assign operands_valid = (state_q == ISSUE);
    assign busy           = (state_q == ISSUE);
    assign proto_err      = proto_err_q;

endmodule

// File: tb/tb_alu_operand_latch.sv
// Directed bench for alu_operand_latch: hand-computed vectors over load ordering,
// unary opcodes, protocol errors, clear and reset.
module tb_alu_operand_latch;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] bus_in;
    logic [3:0]  opcode_in;
    logic        load_a, load_b, load_op, clear, alu_ready;
    logic [15:0] a_out, b_out;
    logic [3:0]  op_out;
    logic        operands_valid, busy, proto_err;

    int n_checks = 0;
    int n_errors = 0;

    alu_operand_latch dut (
        .clock          (clock),
        .reset          (reset),
        .bus_in         (bus_in),
        .opcode_in      (opcode_in),
        .load_a         (load_a),
        .load_b         (load_b),
        .load_op        (load_op),
        .clear          (clear),
        .alu_ready      (alu_ready),
        .a_out          (a_out),
        .b_out          (b_out),
        .op_out         (op_out),
        .operands_valid (operands_valid),
        .busy           (busy),
        .proto_err      (proto_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs set afterwards are stable before the next edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        load_a = 0; load_b = 0; load_op = 0; clear = 0; alu_ready = 0;
    endtask

    task automatic show(input string what);
        $display("[%0t] %s: a=%h b=%h op=%h valid=%b busy=%b perr=%b",
                 $time, what, a_out, b_out, op_out, operands_valid, busy, proto_err);
    endtask

    initial begin
        reset = 1; bus_in = 0; opcode_in = 0;
        idle_inputs();
        step(); step();
        reset = 0;
        show("reset");
        check("rst_a", a_out, 0);
        check("rst_b", b_out, 0);
        check("rst_op", op_out, 0);
        check("rst_valid", operands_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_perr", proto_err, 0);

        // Ordered loads
        bus_in = 16'h1234; load_a = 1; step(); idle_inputs();
        check("ord_valid_a", operands_valid, 0);
        bus_in = 16'h00FF; load_b = 1; step(); idle_inputs();
        check("ord_valid_b", operands_valid, 0);
        opcode_in = 4'h2; load_op = 1; step(); idle_inputs();
        show("ordered set");
        check("ord_valid", operands_valid, 1);
        check("ord_busy", busy, 1);
        check("ord_a", a_out, 16'h1234);
        check("ord_b", b_out, 16'h00FF);
        check("ord_op", op_out, 4'h2);
        alu_ready = 1; step(); idle_inputs();
        show("ordered accept");
        check("ord_acc_valid", operands_valid, 0);
        check("ord_acc_busy", busy, 0);
        check("ord_acc_a_kept", a_out, 16'h1234);

        // All three loads in one cycle, ALU stalls
        bus_in = 16'hA5A5; opcode_in = 4'h1; load_a = 1; load_b = 1; load_op = 1;
        step(); idle_inputs();
        bus_in = 16'hFFFF;
        show("single-cycle set");
        check("sc_valid", operands_valid, 1);
        check("sc_a", a_out, 16'hA5A5);
        check("sc_b", b_out, 16'hA5A5);
        check("sc_op", op_out, 4'h1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", operands_valid, 1);
            check("stall_a", a_out, 16'hA5A5);
            check("stall_b", b_out, 16'hA5A5);
            check("stall_op", op_out, 4'h1);
        end
        alu_ready = 1; step(); idle_inputs();
        check("sc_acc_valid", operands_valid, 0);

        // Unary opcode needs no B
        opcode_in = 4'h8; load_op = 1; step(); idle_inputs();
        check("un_valid_op", operands_valid, 0);
        bus_in = 16'h0F0F; load_a = 1; step(); idle_inputs();
        show("unary set");
        check("un_valid", operands_valid, 1);
        check("un_a", a_out, 16'h0F0F);
        check("un_b_zero", b_out, 0);
        check("un_op", op_out, 4'h8);
        alu_ready = 1; step(); idle_inputs();
        check("un_acc_valid", operands_valid, 0);

        // Binary opcode waits for B
        opcode_in = 4'h2; load_op = 1; step(); idle_inputs();
        bus_in = 16'h1111; load_a = 1; step(); idle_inputs();
        check("bin_wait_valid", operands_valid, 0);
        step(); step();
        check("bin_wait_valid2", operands_valid, 0);
        bus_in = 16'h2222; load_b = 1; step(); idle_inputs();
        show("binary set");
        check("bin_valid", operands_valid, 1);
        check("bin_b", b_out, 16'h2222);

        // Load during ISSUE
        bus_in = 16'hDEAD; load_b = 1; step(); idle_inputs();
        show("load in ISSUE");
        check("pe_b_kept", b_out, 16'h2222);
        check("pe_flag", proto_err, 1);
        check("pe_valid", operands_valid, 1);
        alu_ready = 1; step(); idle_inputs();
        check("pe_acc_valid", operands_valid, 0);
        check("pe_sticky", proto_err, 1);
        step();
        check("pe_sticky2", proto_err, 1);
        clear = 1; step(); idle_inputs();
        show("clear");
        check("pe_cleared", proto_err, 0);
        check("pe_clr_busy", busy, 0);

        // Overwrite, then clear with alu_ready in ISSUE
        bus_in = 16'h0001; load_a = 1; step(); idle_inputs();
        bus_in = 16'h0002; load_a = 1; step(); idle_inputs();
        opcode_in = 4'h2; load_op = 1; step(); idle_inputs();
        check("ow_valid_nob", operands_valid, 0);
        bus_in = 16'h0003; load_b = 1; step(); idle_inputs();
        show("overwrite set");
        check("ow_valid", operands_valid, 1);
        check("ow_a", a_out, 16'h0002);
        check("ow_b", b_out, 16'h0003);
        clear = 1; alu_ready = 1; step(); idle_inputs();
        check("ow_clr_valid", operands_valid, 0);
        check("ow_clr_perr", proto_err, 0);
        opcode_in = 4'h2; load_op = 1; step(); idle_inputs();
        check("ow_need_a", operands_valid, 0);
        bus_in = 16'h0004; load_a = 1; step(); idle_inputs();
        check("ow_need_b", operands_valid, 0);
        bus_in = 16'h0005; load_b = 1; step(); idle_inputs();
        check("ow_refill_valid", operands_valid, 1);

        // Load coinciding with acceptance is dropped and flagged
        bus_in = 16'h7777; load_a = 1; alu_ready = 1; step(); idle_inputs();
        show("load at accept");
        check("la_valid", operands_valid, 0);
        check("la_a_kept", a_out, 16'h0004);
        check("la_perr", proto_err, 1);
        clear = 1; step(); idle_inputs();
        check("la_clr_perr", proto_err, 0);

        // alu_ready already high on entry: exactly one valid cycle
        alu_ready = 1;
        bus_in = 16'h3333; opcode_in = 4'h0; load_a = 1; load_b = 1; load_op = 1;
        step();
        load_a = 0; load_b = 0; load_op = 0;
        check("rdy_valid", operands_valid, 1);
        step(); idle_inputs();
        check("rdy_valid_drop", operands_valid, 0);
        check("rdy_perr", proto_err, 0);

        // Reset mid-handshake
        bus_in = 16'h4444; opcode_in = 4'h3; load_a = 1; load_b = 1; load_op = 1;
        step(); idle_inputs();
        check("mr_valid", operands_valid, 1);
        alu_ready = 1; reset = 1; step(); idle_inputs(); reset = 0;
        show("mid-handshake reset");
        check("mr_a", a_out, 0);
        check("mr_b", b_out, 0);
        check("mr_op", op_out, 0);
        check("mr_valid0", operands_valid, 0);
        check("mr_busy", busy, 0);
        check("mr_perr", proto_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
